// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared op encoding, FSM state encoding and flag bit indices
//               for the alu_flags_seq datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_ADC = 3'd7
    } alu_op_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

    localparam int c_flag_cf = 0;
    localparam int c_flag_zf = 1;
    localparam int c_flag_nf = 2;
    localparam int c_flag_vf = 3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_zero_det.sv
`default_nettype none
// ============================================================================
// Module      : alu_zero_det
// Description : Parametrised OR-reduce zero detector.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_zero_det #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_data,
    output logic         o_zero
);

    assign o_zero = ~|i_data;

endmodule : alu_zero_det
`default_nettype wire

// File: rtl/alu_flags_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_flags_seq
// Description : Sequential ALU with registered C/Z/N/V flags, multi-cycle
//               1-bit-per-cycle shifter and tristate result bus.
//               Define ALU_OVERFLOW_FLAG_EN to enable the signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flags_seq
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic         start,
    input  logic         fi_,
    input  logic         eo_,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] led,
    output logic [N-1:0] bus,
    output logic         cf,
    output logic         zf,
    output logic         nf,
    output logic         vf
);

    localparam int c_kw = $clog2(N);

    alu_state_t       r_state_q, w_state_d;
    alu_op_t          r_op_q,    w_op_d;
    logic             r_fi_q,    w_fi_d;
    logic [N-1:0]     r_sh_q,    w_sh_d;
    logic [c_kw-1:0]  r_cnt_q,   w_cnt_d;
    logic [N-1:0]     r_led_q,   w_led_d;
    logic [3:0]       r_flags_q, w_flags_d;
    logic             r_done_q,  w_done_d;

    logic [N-1:0]     w_opnd_b;
    logic             w_cin;
    logic [N:0]       w_sum;
    logic [c_kw-1:0]  w_k;
    logic [N-1:0]     w_imm_res;
    logic             w_imm_cf;
    logic             w_imm_vf;
    logic [N-1:0]     w_step_val;
    logic             w_step_out;
    logic             w_wr_en;
    logic [N-1:0]     w_wr_val;
    logic             w_wr_cf;
    logic             w_wr_vf;
    logic             w_wr_fi;
    logic             w_zero;

    // Single-cycle result; SUB folds into the adder as a + ~b + 1.
    always_comb begin
        w_opnd_b  = (alu_op_t'(op) == OP_SUB) ? ~b : b;
        w_cin     = 1'b0;
        if (alu_op_t'(op) == OP_SUB) w_cin = 1'b1;
        if (alu_op_t'(op) == OP_ADC) w_cin = r_flags_q[c_flag_cf];
        w_sum     = {1'b0, a} + {1'b0, w_opnd_b} + {{N{1'b0}}, w_cin};
        w_k       = b[c_kw-1:0];
        w_imm_res = w_sum[N-1:0];
        w_imm_cf  = w_sum[N];
        w_imm_vf  = 1'b0;
        case (alu_op_t'(op))
            OP_ADD, OP_SUB, OP_ADC: begin
`ifdef ALU_OVERFLOW_FLAG_EN
                w_imm_vf = (a[N-1] == w_opnd_b[N-1]) && (w_sum[N-1] != a[N-1]);
`else
                w_imm_vf = 1'b0;
`endif
            end
            OP_AND: begin w_imm_res = a & b; w_imm_cf = 1'b0; end
            OP_OR:  begin w_imm_res = a | b; w_imm_cf = 1'b0; end
            OP_XOR: begin w_imm_res = a ^ b; w_imm_cf = 1'b0; end
            default: begin w_imm_res = a; w_imm_cf = 1'b0; end
        endcase
    end

    always_comb begin
        if (r_op_q == OP_SHL) begin
            w_step_val = {r_sh_q[N-2:0], 1'b0};
            w_step_out = r_sh_q[N-1];
        end else begin
            w_step_val = {1'b0, r_sh_q[N-1:1]};
            w_step_out = r_sh_q[0];
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_op_d    = r_op_q;
        w_fi_d    = r_fi_q;
        w_sh_d    = r_sh_q;
        w_cnt_d   = r_cnt_q;
        w_wr_en   = 1'b0;
        w_wr_val  = w_imm_res;
        w_wr_cf   = w_imm_cf;
        w_wr_vf   = w_imm_vf;
        w_wr_fi   = fi_;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_op_d = alu_op_t'(op);
                    w_fi_d = fi_;
                    if ((alu_op_t'(op) == OP_SHL || alu_op_t'(op) == OP_SHR) && (w_k != '0)) begin
                        w_sh_d    = a;
                        w_cnt_d   = w_k;
                        w_state_d = ST_SHIFT;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                w_sh_d  = w_step_val;
                w_cnt_d = r_cnt_q - c_kw'(1);
                // Last step: the shifted-out bit becomes the carry.
                if (r_cnt_q == c_kw'(1)) begin
                    w_wr_en   = 1'b1;
                    w_wr_val  = w_step_val;
                    w_wr_cf   = w_step_out;
                    w_wr_vf   = 1'b0;
                    w_wr_fi   = r_fi_q;
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    alu_zero_det #(.N(N)) u_zero_det (
        .i_data (w_wr_val),
        .o_zero (w_zero)
    );

    always_comb begin
        w_led_d   = r_led_q;
        w_flags_d = r_flags_q;
        w_done_d  = w_wr_en;
        if (w_wr_en) begin
            w_led_d = w_wr_val;
            if (!w_wr_fi) begin
                w_flags_d[c_flag_cf] = w_wr_cf;
                w_flags_d[c_flag_zf] = w_zero;
                w_flags_d[c_flag_nf] = w_wr_val[N-1];
                w_flags_d[c_flag_vf] = w_wr_vf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state_q <= ST_IDLE;
            r_op_q    <= OP_ADD;
            r_fi_q    <= 1'b1;
            r_sh_q    <= '0;
            r_cnt_q   <= '0;
            r_led_q   <= '0;
            r_flags_q <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_op_q    <= w_op_d;
            r_fi_q    <= w_fi_d;
            r_sh_q    <= w_sh_d;
            r_cnt_q   <= w_cnt_d;
            r_led_q   <= w_led_d;
            r_flags_q <= w_flags_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy = (r_state_q == ST_SHIFT);
    assign done = r_done_q;
    assign led  = r_led_q;
    assign bus  = eo_ ? {N{1'bz}} : r_led_q;
    assign cf   = r_flags_q[c_flag_cf];
    assign zf   = r_flags_q[c_flag_zf];
    assign nf   = r_flags_q[c_flag_nf];
    assign vf   = r_flags_q[c_flag_vf];

endmodule : alu_flags_seq
`default_nettype wire

// File: tb/tb_alu_flags_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_flags_seq
// Description : Self-checking bench for alu_flags_seq (N=8) against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_flags_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [N-1:0] t_a = '0;
    logic [N-1:0] t_b = '0;
    logic [2:0]   t_op = '0;
    logic         start = 1'b0;
    logic         fi_ = 1'b1;
    logic         eo_ = 1'b1;
    wire          busy, done, cf, zf, nf, vf;
    wire  [N-1:0] led, bus;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_led = 0;
    int m_cf = 0, m_zf = 0, m_nf = 0, m_vf = 0;

    alu_flags_seq #(.N(N)) dut (
        .clk(clk), .clr(clr), .a(t_a), .b(t_b), .op(t_op), .start(start),
        .fi_(fi_), .eo_(eo_), .busy(busy), .done(done), .led(led), .bus(bus),
        .cf(cf), .zf(zf), .nf(nf), .vf(vf)
    );

    always #5 clk = ~clk;

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic int exp_lat(input int op, input int b);
        return ((op == 5 || op == 6) && (b % 8) != 0) ? (b % 8) : 0;
    endfunction

    function automatic void model_apply(input int op, input int a, input int b, input bit fi);
        int res, c, v, s, k;
        k = b % 8; c = 0; v = 0; res = 0; s = 0;
        case (op)
            0: begin res = a + b;             s = sgn(a) + sgn(b);        end
            1: begin res = a + (255 - b) + 1; s = sgn(a) - sgn(b);        end
            7: begin res = a + b + m_cf;      s = sgn(a) + sgn(b) + m_cf; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = a << k; c = (k != 0) ? ((a >> (8 - k)) & 1) : 0; end
            default: begin res = a >> k; c = (k != 0) ? ((a >> (k - 1)) & 1) : 0; end
        endcase
        if (op == 0 || op == 1 || op == 7) begin
            c = (res >= 256) ? 1 : 0;
            v = (s > 127 || s < -128) ? 1 : 0;
        end
        res = res & 255;
        m_led = res;
        if (!fi) begin
            m_cf = c;
            m_zf = (res == 0) ? 1 : 0;
            m_nf = (res >= 128) ? 1 : 0;
`ifdef ALU_OVERFLOW_FLAG_EN
            m_vf = v;
`else
            m_vf = 0;
`endif
        end
    endfunction

    // Drives one request and measures done cycle / busy cycles / done count,
    // counted from cycle T+1 = 1. Optionally pulses start during cycle T+1.
    task automatic run_op(input int op, input int a, input int b, input bit fi,
                          input bit poke_busy,
                          output int done_cyc, output int busy_cnt, output int done_cnt);
        @(negedge clk);
        t_op = op[2:0]; t_a = a[7:0]; t_b = b[7:0]; fi_ = fi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cyc = -1; busy_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (poke_busy && c == 1 && busy === 1'b1) begin
                t_op = 3'd0; t_a = 8'h11; t_b = 8'h22; fi_ = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b1; t_op = 3'd0; t_a = 8'h01; t_b = 8'h01; fi_ = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({led, cf, zf, nf, vf, busy, done} !== {8'h00, 6'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got led=%h c%b z%b n%b v%b busy%b done%b required all 0",
                     led, cf, zf, nf, vf, busy, done);
        end
        start = 1'b0; clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || led !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_priority: got done=%b led=%h required done=0 led=00", done, led);
        end
        m_led = 0; m_cf = 0; m_zf = 0; m_nf = 0; m_vf = 0;
    endtask

    task automatic test_bus();
        int dc, bc, nc;
        eo_ = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus !== led || led !== 8'h00) begin
            n_fail++;
            $display("FAIL bus_after_reset: got bus=%h led=%h required 00", bus, led);
        end
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, dc, bc, nc);
        model_apply(0, 8'h7F, 8'h01, 1'b0);
        eo_ = 1'b1; #1;
        // Two-state simulators read an undriven net as 0; led is 0x80 so either
        // reading is distinguishable from a driven bus.
        n_checks++;
        if (!(bus === 8'hzz || bus === 8'h00)) begin
            n_fail++;
            $display("FAIL bus_hiz: got bus=%h required zz", bus);
        end
        eo_ = 1'b0; #1;
        n_checks++;
        if (bus !== m_led[7:0]) begin
            n_fail++;
            $display("FAIL bus_drive: got bus=%h required %h", bus, m_led[7:0]);
        end
    endtask

    task automatic test_add_overflow();
        int dc, bc, nc;
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, dc, bc, nc);
        model_apply(0, 8'h7F, 8'h01, 1'b0);
        n_checks++;
        if ({led, cf, zf, nf, vf} !== {m_led[7:0], m_cf[0], m_zf[0], m_nf[0], m_vf[0]} || dc != 1) begin
            n_fail++;
            $display("FAIL add_7f_01: got led=%h c%b z%b n%b v%b done@%0d required led=%h c%0d z%0d n%0d v%0d done@1",
                     led, cf, zf, nf, vf, dc, m_led, m_cf, m_zf, m_nf, m_vf);
        end
    endtask

    task automatic test_sub_flag_hold();
        int dc, bc, nc;
        run_op(1, 8'h05, 8'h05, 1'b0, 1'b0, dc, bc, nc);
        model_apply(1, 8'h05, 8'h05, 1'b0);
        n_checks++;
        if ({led, cf, zf, nf, vf} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_equal: got led=%h c%b z%b n%b v%b required led=00 c1 z1 n0 v0",
                     led, cf, zf, nf, vf);
        end
        run_op(1, 8'h06, 8'h05, 1'b1, 1'b0, dc, bc, nc);
        model_apply(1, 8'h06, 8'h05, 1'b1);
        n_checks++;
        if ({led, cf, zf, nf, vf} !== {8'h01, 1'b1, 1'b1, 1'b0, 1'b0} || nc != 1) begin
            n_fail++;
            $display("FAIL sub_flag_hold: got led=%h c%b z%b n%b v%b dones=%0d required led=01 c1 z1 n0 v0 dones=1",
                     led, cf, zf, nf, vf, nc);
        end
    endtask

    task automatic test_shl_busy();
        int dc, bc, nc;
        run_op(5, 8'h81, 8'h03, 1'b0, 1'b1, dc, bc, nc);
        model_apply(5, 8'h81, 8'h03, 1'b0);
        n_checks++;
        if (bc != 3 || dc != 4 || nc != 1) begin
            n_fail++;
            $display("FAIL shl_timing: got busy=%0d done@%0d dones=%0d required 3, 4, 1", bc, dc, nc);
        end
        n_checks++;
        if ({led, cf, zf, nf} !== {8'h08, 3'b000}) begin
            n_fail++;
            $display("FAIL shl_result: got led=%h c%b z%b n%b required led=08 c0 z0 n0", led, cf, zf, nf);
        end
    endtask

    task automatic test_shr_clr_abort();
        int seen_done;
        @(negedge clk);
        t_op = 3'd6; t_a = 8'h81; t_b = 8'h02; fi_ = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL shr_busy_before_clr: got busy=%b required 1", busy);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1) seen_done++;
            if (c == 0) begin
                n_checks++;
                if ({led, busy, cf, zf, nf, vf} !== {8'h00, 5'b0}) begin
                    n_fail++;
                    $display("FAIL shr_abort_state: got led=%h busy%b c%b z%b n%b v%b required all 0",
                             led, busy, cf, zf, nf, vf);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL shr_abort_done: got %0d done pulses required 0", seen_done);
        end
        m_led = 0; m_cf = 0; m_zf = 0; m_nf = 0; m_vf = 0;
    endtask

    task automatic test_adc();
        int dc, bc, nc;
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, dc, bc, nc);
        model_apply(0, 8'hFF, 8'h01, 1'b0);
        run_op(7, 8'hFF, 8'h00, 1'b0, 1'b0, dc, bc, nc);
        model_apply(7, 8'hFF, 8'h00, 1'b0);
        n_checks++;
        if ({led, cf, zf, vf} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL adc_carry_in: got led=%h c%b z%b v%b required led=00 c1 z1 v0", led, cf, zf, vf);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        t_op = 3'd0; t_a = 8'h12; t_b = 8'h34; fi_ = 1'b0; start = 1'b1;
        @(negedge clk);
        model_apply(0, 8'h12, 8'h34, 1'b0);
        n_checks++;
        if (done !== 1'b1 || led !== m_led[7:0]) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b led=%h required done=1 led=%h", done, led, m_led[7:0]);
        end
        t_op = 3'd4; t_a = 8'hF0; t_b = 8'h0F; fi_ = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_apply(4, 8'hF0, 8'h0F, 1'b0);
        n_checks++;
        if (done !== 1'b1 || {led, cf, zf, nf, vf} !== {m_led[7:0], m_cf[0], m_zf[0], m_nf[0], m_vf[0]}) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b led=%h c%b z%b n%b v%b required done=1 led=%h c%0d z%0d n%0d v%0d",
                     done, led, cf, zf, nf, vf, m_led, m_cf, m_zf, m_nf, m_vf);
        end
    endtask

    task automatic test_random();
        int dc, bc, nc, op, a, b, lat;
        bit fi;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            fi = ($urandom_range(0, 3) == 0);
            lat = exp_lat(op, b);
            run_op(op, a, b, fi, 1'b0, dc, bc, nc);
            model_apply(op, a, b, fi);
            n_checks++;
            if ({led, cf, zf, nf, vf} !== {m_led[7:0], m_cf[0], m_zf[0], m_nf[0], m_vf[0]} ||
                dc != lat + 1 || bc != lat || nc != 1) begin
                n_fail++;
                $display("FAIL random_%0d op%0d a=%h b=%h fi=%b: got led=%h c%b z%b n%b v%b done@%0d busy=%0d dones=%0d required led=%h c%0d z%0d n%0d v%0d done@%0d busy=%0d dones=1",
                         i, op, a, b, fi, led, cf, zf, nf, vf, dc, bc, nc,
                         m_led, m_cf, m_zf, m_nf, m_vf, lat + 1, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bus();
        test_add_overflow();
        test_sub_flag_hold();
        test_shl_busy();
        test_shr_clr_abort();
        test_adc();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_flags_seq
`default_nettype wire
